// File: rtl/cic_pkg.sv
// Shared constants and helpers for the multi-channel-ready CIC decimator.
// Width sizing, round-half-up shift and saturation detection.
package cic_pkg;

  localparam int ORDER_MAX = 5;
  localparam int CALC_W    = 64;

  function automatic int min_reg_width(
    input int in_w,
    input int order,
    input int ratio_w
  );
    return in_w + order * ratio_w + 1;
  endfunction

  // Round half up then arithmetic shift; v is already sign-extended.
  function automatic logic signed [CALC_W-1:0] round_shift(
    input logic signed [CALC_W-1:0] v,
    input logic [7:0]               s
  );
    logic signed [CALC_W-1:0] r;
    r = v;
    if (s != 8'd0) begin
      r = r + (CALC_W'(1) << (s - 8'd1));
    end
    return r >>> s;
  endfunction

  function automatic logic sat_clip(
    input logic signed [CALC_W-1:0] v,
    input int unsigned              ow
  );
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = $signed((CALC_W'(1) << (ow - 1)) - CALC_W'(1));
    lo = -hi - CALC_W'(1);
    return (v > hi) || (v < lo);
  endfunction

endpackage

// File: rtl/cic_out_fifo.sv
// Two-entry valid/ready result buffer; a push into a full buffer
// with no pop in the same cycle is dropped and flagged.
module cic_out_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         drop
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;
  logic              full;
  logic              acc;

  always_comb begin
    full  = (cnt_q == 2'd2);
    pop   = (cnt_q != 2'd0) && out_ready;
    acc   = push_valid && (!full || pop);
    drop  = push_valid && full && !pop;
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + {1'b0, acc} - {1'b0, pop};
    if (acc) begin
      mem_d[wr_q] = push_data;
      wr_d        = !wr_q;
    end
    if (pop) begin
      rd_d = !rd_q;
    end
    if (rst || flush) begin
      mem_d = '0;
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    wr_q  <= wr_d;
    rd_q  <= rd_d;
    cnt_q <= cnt_d;
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;

endmodule

// File: rtl/cic_decimator_nch.sv
// N-order CIC decimator: integrators, comb, round/shift/saturate,
// settling discard and a 2-entry output buffer with sticky flags.
module cic_decimator_nch
  import cic_pkg::*;
#(
  parameter int ORDER       = 3,
  parameter int IN_WIDTH    = 1,
  parameter int IN_SIGNED   = 0,
  parameter int REG_WIDTH   = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int RATIO_WIDTH = 10,
  parameter int SHIFT_WIDTH = $clog2(REG_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   restart,
  input  logic                   enable_in,
  input  logic [IN_WIDTH-1:0]    data_in,
  input  logic [RATIO_WIDTH-1:0] dec_ratio,
  input  logic [SHIFT_WIDTH-1:0] out_shift,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clr_flags,
  output logic                   overrun,
  output logic                   saturated
);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  if (ORDER < 1 || ORDER > ORDER_MAX) begin : g_bad_order
    $error("cic_decimator_nch: ORDER out of range");
  end
  if (REG_WIDTH < min_reg_width(IN_WIDTH, ORDER, RATIO_WIDTH) ||
      REG_WIDTH >= CALC_W) begin : g_bad_width
    $error("cic_decimator_nch: REG_WIDTH out of range");
  end

  logic                   clr;
  logic [RATIO_WIDTH-1:0] rlast_q, rlast_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic                   strobe_q, strobe_d;
  logic [2:0]             settle_q, settle_d;
  logic [REG_WIDTH-1:0]   dn_q, dn_d;
  logic                   dn_vld_q, dn_vld_d;
  logic                   ovr_q, ovr_d;
  logic                   sat_q, sat_d;

  logic [REG_WIDTH-1:0]   ext_in;
  logic [REG_WIDTH-1:0]   acc_q [ORDER];
  logic [REG_WIDTH-1:0]   acc_d [ORDER];
  logic [REG_WIDTH-1:0]   dly_q [ORDER];
  logic [REG_WIDTH-1:0]   dly_d [ORDER];
  logic [REG_WIDTH-1:0]   cmb   [ORDER+1];

  logic signed [CALC_W-1:0] scaled;
  logic                     clip;
  logic                     push;
  logic                     drop;
  logic [OUT_WIDTH-1:0]     push_data;

  assign clr = rst || restart;

  if (IN_SIGNED != 0) begin : g_sx
    assign ext_in = {{(REG_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
  end else begin : g_zx
    assign ext_in = {{(REG_WIDTH-IN_WIDTH){1'b0}}, data_in};
  end

  // Integrators run on enabled cycles; combs advance only at T+1.
  assign cmb[0] = acc_q[ORDER-1];

  for (genvar k = 0; k < ORDER; k++) begin : g_stage
    logic [REG_WIDTH-1:0] src;
    if (k == 0) begin : g_first
      assign src = ext_in;
    end else begin : g_next
      assign src = acc_q[k-1];
    end
    assign acc_d[k]   = clr       ? '0 :
                        enable_in ? acc_q[k] + src : acc_q[k];
    assign cmb[k+1]   = cmb[k] - dly_q[k];
    assign dly_d[k]   = clr       ? '0 :
                        strobe_q  ? cmb[k] : dly_q[k];
  end

  always_comb begin
    rlast_d  = rlast_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    settle_d = settle_q;
    dn_d     = dn_q;
    dn_vld_d = 1'b0;
    if (clr) begin
      rlast_d  = (dec_ratio < RATIO_WIDTH'(2)) ?
                 RATIO_WIDTH'(1) : dec_ratio - RATIO_WIDTH'(1);
      shift_d  = out_shift;
      cnt_d    = '0;
      settle_d = '0;
      dn_d     = '0;
    end else begin
      if (enable_in) begin
        if (cnt_q == rlast_q) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + RATIO_WIDTH'(1);
        end
      end
      if (strobe_q) begin
        dn_d = cmb[ORDER];
        if (settle_q == 3'(ORDER)) begin
          dn_vld_d = 1'b1;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
    end
  end

  assign scaled = round_shift(
    {{(CALC_W-REG_WIDTH){dn_q[REG_WIDTH-1]}}, dn_q}, 8'(shift_q));
  assign clip = sat_clip(scaled, OUT_WIDTH);

  always_comb begin
    push_data = scaled[OUT_WIDTH-1:0];
    if (clip) begin
      push_data = scaled[CALC_W-1] ? OUT_MIN : OUT_MAX;
    end
  end

  assign push = dn_vld_q && !clr;

  cic_out_fifo #(
    .W(OUT_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (restart),
    .push_valid (push),
    .push_data  (push_data),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .drop       (drop)
  );

  // Set beats clear; rst clears regardless.
  always_comb begin
    ovr_d = ovr_q;
    sat_d = sat_q;
    if (clr_flags) begin
      ovr_d = 1'b0;
      sat_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end
    if (push && !drop && clip) begin
      sat_d = 1'b1;
    end
    if (rst) begin
      ovr_d = 1'b0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    rlast_q  <= rlast_d;
    shift_q  <= shift_d;
    cnt_q    <= cnt_d;
    strobe_q <= strobe_d;
    settle_q <= settle_d;
    dn_q     <= dn_d;
    dn_vld_q <= dn_vld_d;
    ovr_q    <= ovr_d;
    sat_q    <= sat_d;
    for (int k = 0; k < ORDER; k++) begin
      acc_q[k] <= acc_d[k];
      dly_q[k] <= dly_d[k];
    end
  end

  assign overrun   = ovr_q;
  assign saturated = sat_q;

endmodule

// File: doc/cic_decimator_nch.md
Name: cic_decimator_nch

Overview:
- Parametrised successor to the single-bit sinc3 decimator used behind the VCO-ADC front end.
- Configurable CIC order and input width, unsigned or two's-complement input, runtime decimation ratio and output shift.
- Output path: round-half-up, saturate, settling-sample discard.
- Results delivered through a 2-entry valid/ready output buffer with sticky overrun and saturation flags.
- Sits between the VCO phase-count quantiser and the bus/serialiser that collects ADC words.

Parameters:
- ORDER, 3: CIC order N; legal 1..5.
- IN_WIDTH, 1: input sample width.
- IN_SIGNED, 0: 1 = data_in is two's complement; 0 = unsigned, zero-extended.
- REG_WIDTH, 32: integrator/comb width. Must be ≥ IN_WIDTH+IN_SIGNED... ≥ IN_WIDTH + ORDER*RATIO_WIDTH + 1.
- OUT_WIDTH, 16: signed output width.
- RATIO_WIDTH, 10: width of dec_ratio.
- SHIFT_WIDTH, $clog2(REG_WIDTH): width of out_shift.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- restart  in  1  synchronous soft restart of datapath; relatches config
- enable_in  in  1  input sample strobe; data_in consumed when high
- data_in  in  IN_WIDTH  input sample
- dec_ratio  in  RATIO_WIDTH  decimation ratio R; values 0 and 1 are treated as 2
- out_shift  in  SHIFT_WIDTH  arithmetic right shift applied before saturation
- out_data  out  OUT_WIDTH  signed decimated sample (FIFO head)
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accept; pop when out_valid && out_ready
- clr_flags  in  1  clears overrun and saturated
- overrun  out  1  sticky; result dropped because FIFO full
- saturated  out  1  sticky; a pushed result was clipped

Behaviour:
- Reset (rst):
  - Clears integrators, comb delays, sample counter, settle counter, FIFO and flags.
  - Latches dec_ratio and out_shift.
  - out_valid=0, out_data=0, overrun=0, saturated=0.
- restart:
  - Same clears and relatch as rst, except overrun/saturated are kept.
  - FIFO is flushed.
  - rst has priority over restart.
- Config: dec_ratio and out_shift are used only as latched; changes without restart/rst are ignored.
- Integrators:
  - On an enable_in cycle: acc1 += ext(data_in); acck += acc(k-1) for k = 2..N. All use registered old values.
  - Arithmetic is modulo 2^REG_WIDTH. Wrap is intended.
- Sample counter:
  - Counts enabled cycles 0..R-1.
  - The enabled cycle with count==R-1 is strobe cycle T; the counter wraps to 0.
- Comb chain:
  - At cycle T+1 (independent of enable_in), d0 = accN register; dk = d(k-1) − d(k-1)_delay, combinational through N stages.
  - dN is registered at the end of T+1; delays update at the same edge.
- Settling: the first N decimated results after rst/restart are discarded (not pushed, no flags).
- Scaling, registered at the end of T+2:
  - If s>0, add 2^(s-1) to dN.
  - Arithmetic shift right by s.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Clipping sets saturated.
- FIFO:
  - 2 entries. Push at the end of T+2.
  - If empty, out_valid rises at T+3.
  - Push while full with a pop in the same cycle is accepted.
  - Push while full without a pop drops the new result and sets overrun.
  - Order is preserved.
- Flags:
  - clr_flags clears both flags.
  - Simultaneous clr_flags and a set event: the set wins.
- Pop with out_valid=0 is ignored.

Decomposition:
- Package cic_pkg:
  - ORDER_MAX=5.
  - Function to compute minimum REG_WIDTH.
  - Saturate/round helper function.
- One sub-module, cic_out_fifo: a 2-entry valid/ready buffer with an overflow-drop indication, reusable by later multi-channel versions.
- Integrator/comb chains are generate loops in the top module.

Test Plan:
- DC gain: ORDER=3, IN_WIDTH=1, data_in=1 continuous, R=16, shift=0 → after 3 discarded results, every output = 4096; out_valid first at (4·16−1)+3 cycles after enable. Repeat with shift=12 → output 1.
- Rounding: R=2, data_in=1 → raw 8. With shift=4, out_data=1 (0.5 rounds up); with shift=5, out_data=0.
- Saturation: IN_WIDTH=4, data_in=15, R=64, shift=0 → raw 3932160 → out_data=32767, saturated=1. clr_flags → 0, then re-set on the next clipped result.
- Backpressure: out_ready=0 across 4 results → out_valid held, 2 entries kept, overrun=1. Drain → first two results in order. Also check a push and pop in the same cycle while full → no overrun.
- Gapped enable: enable_in toggled 50% with R=16 → identical output values (4096); spacing 32 cycles.
- Restart/reset mid-run:
  - Change dec_ratio to 8 and pulse restart with the FIFO full → out_valid=0 next cycle, flags kept, 3 results discarded, then 512.
  - rst asserted in the same cycle → flags cleared too.
